// File: rtl/i2c_pkg.sv
// Shared I2C bit-level command codes and the bit transmitter state type.
package i2c_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_1     = 3'd2;
  localparam logic [2:0] CMD_0     = 3'd3;
  localparam logic [2:0] CMD_STOP  = 3'd4;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  function automatic logic [2:0] cmd_decode(input logic [2:0] cmd);
    return (cmd > CMD_STOP) ? CMD_IDLE : cmd;
  endfunction

  // Returns {scl_oe, sda_oe} for a tap; IDLE keeps whatever the lines were doing.
  function automatic logic [1:0] tap_lines(input logic [2:0] cmd, input logic [1:0] tap,
                                           input logic [1:0] prev);
    logic [1:0] lines;
    lines = prev;
    case (cmd)
      CMD_START: begin
        case (tap)
          2'd0:    lines = 2'b10;
          2'd1:    lines = 2'b00;
          2'd2:    lines = 2'b01;
          default: lines = 2'b11;
        endcase
      end
      CMD_1:    lines = (tap == 2'd1 || tap == 2'd2) ? 2'b00 : 2'b10;
      CMD_0:    lines = (tap == 2'd1 || tap == 2'd2) ? 2'b01 : 2'b11;
      CMD_STOP: begin
        case (tap)
          2'd0:    lines = 2'b11;
          2'd1:    lines = 2'b01;
          default: lines = 2'b00;
        endcase
      end
      default:  lines = prev;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/i2c_in_sync.sv
// Two-flop synchronisers for the SCL/SDA pad inputs; reset to 1 so an idle bus is assumed.
module i2c_in_sync (
  input  logic clock,
  input  logic rst_n,
  input  logic scl_async,
  input  logic sda_async,
  output logic scl_sync,
  output logic sda_sync
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
    end else begin
      scl_ff <= {scl_ff[0], scl_async};
      sda_ff <= {sda_ff[0], sda_async};
    end
  end

  assign scl_sync = scl_ff[1];
  assign sda_sync = sda_ff[1];

endmodule

// File: rtl/i2c_bit_tras.sv
// Bit-level I2C transmitter: each command runs as four CLK_DIV-long taps on open-drain enables.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during tap1.
module i2c_bit_tras
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       tras_cmd_vld,
  input  logic [2:0] tras_cmd,
  output logic       tras_cmd_ready,
  output logic       rx_bit_vld,
  output logic       rx_bit,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  state_e          state;
  logic [2:0]      cmd_lat;
  logic [1:0]      tap_cnt;
  logic [DivW-1:0] div_cnt;
  logic            scl_s;
  logic            sda_s;
  logic            stretch_hold;
  logic            is_bit;

  i2c_in_sync u_in_sync (
    .clock     (clock),
    .rst_n     (rst_n),
    .scl_async (scl_i),
    .sda_async (sda_i),
    .scl_sync  (scl_s),
    .sda_sync  (sda_s)
  );

`ifdef I2C_CLK_STRETCH_EN
  assign stretch_hold = (tap_cnt == 2'd1) && (cmd_lat != CMD_IDLE) && !scl_s;
`else
  logic unused_scl;
  assign unused_scl   = scl_s;
  assign stretch_hold = 1'b0;
`endif

  assign is_bit = (cmd_lat == CMD_1) || (cmd_lat == CMD_0);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cmd_lat          <= CMD_IDLE;
      tap_cnt          <= 2'd0;
      div_cnt          <= '0;
      tras_cmd_ready   <= 1'b0;
      rx_bit_vld       <= 1'b0;
      rx_bit           <= 1'b0;
      busy             <= 1'b0;
      {scl_oe, sda_oe} <= 2'b00;
    end else begin
      rx_bit_vld <= 1'b0;
      unique case (state)
        S_IDLE: begin
          tras_cmd_ready <= 1'b1;
          if (tras_cmd_vld && tras_cmd_ready) begin
            state            <= S_RUN;
            tras_cmd_ready   <= 1'b0;
            cmd_lat          <= cmd_decode(tras_cmd);
            tap_cnt          <= 2'd0;
            div_cnt          <= '0;
            {scl_oe, sda_oe} <= tap_lines(cmd_decode(tras_cmd), 2'd0, {scl_oe, sda_oe});
          end
        end
        S_RUN: begin
          if (stretch_hold) begin
            div_cnt <= '0;
          end else if (div_cnt != DivLast) begin
            div_cnt <= div_cnt + DivW'(1);
          end else begin
            div_cnt <= '0;
            // Last cycle of tap2: SCL has been high for a full tap, data is stable.
            if (tap_cnt == 2'd2 && is_bit) rx_bit <= sda_s;
            if (tap_cnt == 2'd3) begin
              state          <= S_IDLE;
              tras_cmd_ready <= 1'b1;
              tap_cnt        <= 2'd0;
              rx_bit_vld     <= is_bit;
              if (cmd_lat == CMD_START) busy <= 1'b1;
              if (cmd_lat == CMD_STOP)  busy <= 1'b0;
            end else begin
              tap_cnt          <= tap_cnt + 2'd1;
              {scl_oe, sda_oe} <= tap_lines(cmd_lat, tap_cnt + 2'd1, {scl_oe, sda_oe});
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
